// File: rtl/seq_shifter_if.sv
// Start/busy/done handshake and operand/result bus for the multi-cycle shifter.
// The controller drives the request side; the shifter drives the status/result side.
interface seq_shifter_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic [1:0]       shift;
  logic [AMT_W-1:0] amt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sout;

  modport master (output start, in, shift, amt, input  busy, done, sout);
  modport slave  (input  start, in, shift, amt, output busy, done, sout);
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: moves the operand one bit position per clock for amt steps.
// Uses the datapath shift-op encoding and exposes a Moore busy/done handshake.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  seq_shifter_if.slave bus
);

  typedef enum logic [1:0] {OP_PASS = 2'b00, OP_SHL = 2'b01, OP_SHR = 2'b10, OP_SAR = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] work;
    op_e              op;
    logic [AMT_W-1:0] cnt;
  } job_t;

  state_e           state_q, state_d;
  job_t             job_q, job_d;
  logic [WIDTH-1:0] sout_q, sout_d;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] w, input op_e op);
    case (op)
      OP_SHL:  step = {w[WIDTH-2:0], 1'b0};
      OP_SHR:  step = {1'b0, w[WIDTH-1:1]};
      OP_SAR:  step = {w[WIDTH-1], w[WIDTH-1:1]};
      default: step = w;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    sout_d  = sout_q;
    unique case (state_q)
      S_IDLE: begin
        // Only a definite 1 leaves IDLE; an unknown start falls to the idle path.
        if (bus.start == 1'b1) begin
          job_d.work = bus.in;
          job_d.op   = op_e'(bus.shift);
          job_d.cnt  = bus.amt;
          if (bus.amt == '0 || bus.shift == 2'b00) begin
            sout_d  = bus.in;
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        job_d.work = step(job_q.work, job_q.op);
        job_d.cnt  = job_q.cnt - AMT_W'(1);
        if (job_q.cnt == AMT_W'(1)) begin
          sout_d  = step(job_q.work, job_q.op);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      job_q   <= '0;
      sout_q  <= '0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      sout_q  <= sout_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.sout = sout_q;

endmodule
